// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and widths for the SPI mode 0 responder
package spi_pkg;
  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins plus TX/RX user handshake bundle
interface spi_slave_if;
  import spi_pkg::*;

  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              tx_underrun;
  logic              frame_abort;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchronizer with registered rise/fall strobes
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end
endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 responder: oversampled pins, MSB-first byte shifting,
// one-entry TX holding register, RX strobe and underrun/abort flags
module spi_slave
  import spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_if.slave      bus
);
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs resets to the asserted level so a frame in flight at reset release is ignored
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_chain <= '0;
    else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.spi_mosi};
  end
  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]      tx_shift, tx_shift_nxt, rx_shift, hold_data, consume_byte;
  logic                   hold_valid, load, consume, byte_done;
  logic                   miso_q, oe_q, busy_q, rx_valid_q, underrun_q, abort_q;
  logic [BYTE_W-1:0]      rx_data_q;

  always_comb begin
    load         = bus.tx_valid & ~hold_valid;
    byte_done    = (state == SHIFT) && sclk_rise && (bit_cnt == '1);
    consume      = ((state == IDLE) && cs_fall) || byte_done;
    consume_byte = hold_valid ? hold_data : DEFAULT_TX;
    bit_cnt_nxt  = ((state == SHIFT) && sclk_rise) ? bit_cnt + 1'b1 : bit_cnt;
    tx_shift_nxt = tx_shift;
    if (consume)
      tx_shift_nxt = consume_byte;
    // the first fall of a byte keeps the fresh MSB on the line
    else if ((state == SHIFT) && sclk_fall && (bit_cnt != '0))
      tx_shift_nxt = {tx_shift[BYTE_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      tx_shift   <= tx_shift_nxt;

      if (consume) begin
        if (hold_valid) hold_valid <= 1'b0;
        else            underrun_q <= 1'b1;
      end
      // a load into an empty register is kept for the next consume point
      if (load) begin
        hold_data  <= bus.tx_data;
        hold_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            oe_q    <= 1'b1;
            miso_q  <= tx_shift_nxt[BYTE_W-1];
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[BYTE_W-2:0], mosi_sync};
            bit_cnt  <= bit_cnt_nxt;
            if (byte_done) begin
              rx_data_q  <= {rx_shift[BYTE_W-2:0], mosi_sync};
              rx_valid_q <= 1'b1;
            end
          end
          if (cs_rise) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            abort_q <= (bit_cnt_nxt != '0);
          end else begin
            miso_q  <= tx_shift_nxt[BYTE_W-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.tx_ready    = ~hold_valid;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = busy_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;
  localparam int          S      = 2;
  localparam logic [7:0]  DEF_TX = 8'hFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_if bus ();

  spi_slave #(.SYNC_STAGES(S), .DEFAULT_TX(DEF_TX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int         rx_cnt = 0, und_cnt = 0, abort_cnt = 0;
  logic [7:0] rx_log [256];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt % 256] = bus.rx_data;
      rx_cnt++;
    end
    if (bus.tx_underrun) und_cnt++;
    if (bus.frame_abort) abort_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: bench still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // frame stimulus buffers
  logic [7:0] mosi_b  [4];
  logic [7:0] miso_b  [4];
  logic       load_en [4];
  logic [7:0] load_d  [4];
  logic [7:0] hq [$];

  task automatic do_load(input logic [7:0] d);
    int n = 0;
    while (!bus.tx_ready && n < 50) begin
      wait_clk(1);
      n++;
    end
    check("load_ready", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic spi_frame(input int nbits, input int h);
    bus.spi_cs_n = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      int b  = k / 8;
      int bi = 7 - (k % 8);
      bus.spi_mosi = mosi_b[b][bi];
      wait_clk(h);
      if (k == 0) begin
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_oe", 32'(bus.spi_miso_oe), 32'd1);
        check("start_tx_ready", 32'(bus.tx_ready), 32'd1);
      end
      if ((k % 8) == 3 && load_en[b]) do_load(load_d[b]);
      miso_b[b][bi] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      wait_clk(h);
      bus.spi_sclk = 1'b0;
    end
    wait_clk(h);
    bus.spi_cs_n = 1'b1;
    wait_clk(h);
  endtask

  // Reference: every consume point takes the oldest held byte or the default
  task automatic run_frame(input string tag, input int nbits, input int h);
    int         nfull = nbits / 8;
    int         part  = nbits % 8;
    int         r0 = rx_cnt, u0 = und_cnt, a0 = abort_cnt;
    int         eu = 0;
    logic [7:0] exp_tx [5];
    for (int c = 0; c <= nfull; c++) begin
      if (c > 0 && load_en[c-1]) hq.push_back(load_d[c-1]);
      if (hq.size() > 0) exp_tx[c] = hq.pop_front();
      else begin
        exp_tx[c] = DEF_TX;
        eu++;
      end
    end
    if (part != 0 && load_en[nfull]) hq.push_back(load_d[nfull]);

    spi_frame(nbits, h);

    for (int b = 0; b < nfull; b++) begin
      check($sformatf("%s_miso%0d", tag, b), 32'(miso_b[b]), 32'(exp_tx[b]));
      check($sformatf("%s_rx%0d", tag, b), 32'(rx_log[(r0 + b) % 256]), 32'(mosi_b[b]));
    end
    if (part != 0)
      check($sformatf("%s_miso_part", tag), 32'(miso_b[nfull] >> (8 - part)),
            32'(exp_tx[nfull] >> (8 - part)));
    if (nfull > 0) check($sformatf("%s_rx_hold", tag), 32'(bus.rx_data), 32'(mosi_b[nfull-1]));
    check($sformatf("%s_rx_cnt", tag), rx_cnt - r0, nfull);
    check($sformatf("%s_underrun", tag), und_cnt - u0, eu);
    check($sformatf("%s_abort", tag), abort_cnt - a0, (part != 0) ? 1 : 0);
    check($sformatf("%s_end_busy", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s_end_oe", tag), 32'(bus.spi_miso_oe), 32'd0);
    check($sformatf("%s_tx_ready", tag), 32'(bus.tx_ready), (hq.size() == 0) ? 1 : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
    check({tag, "_oe"}, 32'(bus.spi_miso_oe), 32'd0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_underrun"}, 32'(bus.tx_underrun), 32'd0);
    check({tag, "_abort"}, 32'(bus.frame_abort), 32'd0);
  endtask

  typedef struct {
    logic       load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vt [4];

  initial begin
    int r0, u0;

    // single-byte frames; a one-byte frame consumes at start and at its end
    vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
    vt[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 2};
    vt[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
    vt[3] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 2};

    rst_n        = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) load_en[i] = 1'b0;
    wait_clk(3);
    check_reset_vals("por");
    rst_n = 1'b1;
    wait_clk(6);

    for (int i = 0; i < 4; i++) begin
      if (vt[i].load) do_load(vt[i].tx);
      mosi_b[0] = vt[i].mosi;
      r0 = rx_cnt;
      u0 = und_cnt;
      spi_frame(8, 6);
      check($sformatf("vec%0d_miso", i), 32'(miso_b[0]), 32'(vt[i].exp_miso));
      check($sformatf("vec%0d_rx", i), 32'(bus.rx_data), 32'(vt[i].exp_rx));
      check($sformatf("vec%0d_rx_cnt", i), rx_cnt - r0, 1);
      check($sformatf("vec%0d_underrun", i), und_cnt - u0, vt[i].exp_und);
    end

    // two-byte frame with refills during each byte
    do_load(8'h11);
    hq.push_back(8'h11);
    mosi_b[0] = 8'h81; mosi_b[1] = 8'h42;
    load_en[0] = 1'b1; load_d[0] = 8'h22;
    load_en[1] = 1'b1; load_d[1] = 8'h33;
    run_frame("two_byte", 16, 6);
    check("two_byte_first", 32'(miso_b[0]), 32'h11);
    check("two_byte_second", 32'(miso_b[1]), 32'h22);

    // abort after 4 clocks; the byte loaded mid-byte is retained for the next frame
    mosi_b[0] = 8'hE7;
    load_en[0] = 1'b1; load_d[0] = 8'hC3;
    load_en[1] = 1'b0;
    run_frame("abort", 4, 6);
    load_en[0] = 1'b0;
    mosi_b[0] = 8'h5A;
    run_frame("after_abort", 8, 6);
    check("after_abort_miso", 32'(miso_b[0]), 32'hC3);

    // reset mid-byte with CS held low
    r0 = rx_cnt;
    bus.spi_cs_n = 1'b0;
    wait_clk(6);
    for (int k = 0; k < 3; k++) begin
      bus.spi_mosi = k[0];
      wait_clk(6);
      bus.spi_sclk = 1'b1;
      wait_clk(6);
      bus.spi_sclk = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    wait_clk(2);
    rst_n = 1'b1;
    hq.delete();
    for (int k = 0; k < 8; k++) begin
      wait_clk(6);
      bus.spi_sclk = 1'b1;
      wait_clk(6);
      bus.spi_sclk = 1'b0;
    end
    wait_clk(6);
    check("rst_ignored_rx", rx_cnt - r0, 0);
    check("rst_ignored_busy", 32'(bus.busy), 32'd0);
    bus.spi_cs_n = 1'b1;
    wait_clk(8);
    mosi_b[0] = 8'h96;
    run_frame("post_rst", 8, 6);

    // random 4-byte frames, first one at the minimum phase length
    for (int it = 0; it < 10; it++) begin
      int h = (it == 0) ? S + 3 : S + 3 + int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] d = 8'($urandom);
        do_load(d);
        hq.push_back(d);
      end
      for (int b = 0; b < 4; b++) begin
        mosi_b[b]  = 8'($urandom);
        load_en[b] = 1'($urandom_range(0, 1));
        load_d[b]  = 8'($urandom);
      end
      run_frame($sformatf("rnd%0d", it), 32, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
